// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared definitions for the sync_fifo_flex family.
//   read_mode_e      : read-mode encodings (MODE_STD, MODE_FWFT).
//   count_width(aw)  : width of an occupancy counter able to hold 0..2**aw.
package sync_fifo_pkg;

  typedef enum logic {
    MODE_STD  = 1'b0,
    MODE_FWFT = 1'b1
  } read_mode_e;

  function automatic int count_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: DEPTH x DATA_WIDTH storage array for sync_fifo_flex.
// Ports:
//   clk      : write clock (posedge)
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_raddr  : read address (asynchronous read)
//   o_rdata  : read data, combinational from i_raddr
// Contents are never cleared.
module sync_fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: single-clock FIFO with occupancy count, programmable
// almost-full / almost-empty flags and selectable read mode.
// Parameters: DATA_WIDTH, ADDR_WIDTH (DEPTH = 2**ADDR_WIDTH), AF_THRESH,
//   AE_THRESH, FWFT (0 = registered read, 1 = first-word-fall-through).
// Ports:
//   clk, rst      : clock (posedge), synchronous active-high reset
//   wr_en/data_in : write request and data
//   rd_en         : read request (pops head word in FWFT mode)
//   data_out      : read data
//   data_valid    : data_out holds a valid word
//   full/empty    : count == DEPTH / count == 0
//   almost_full   : count >= AF_THRESH
//   almost_empty  : count <= AE_THRESH
//   count         : occupancy 0..DEPTH
// Optional macro SYNC_FIFO_ERR_FLAGS_EN adds sticky overflow / underflow
// outputs (cleared only by rst).
module sync_fifo_flex
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = 2**ADDR_WIDTH - 2,
  parameter int AE_THRESH  = 2,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int CW    = count_width(ADDR_WIDTH);
  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [ADDR_WIDTH:0]   r_wr_ptr;
  logic [ADDR_WIDTH:0]   r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [DATA_WIDTH-1:0] w_rd_data;

  // Flags decode from the registered count only, so they move one cycle
  // after the accepting edge.
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  // Gating with rst keeps requests in the reset cycle out of the RAM too.
  assign w_wr_acc = wr_en & ~w_full  & ~rst;
  assign w_rd_acc = rd_en & ~w_empty & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_wr_acc) - CW'(w_rd_acc);
    end
  end

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr[ADDR_WIDTH-1:0]),
    .i_wdata (data_in),
    .i_raddr (r_rd_ptr[ADDR_WIDTH-1:0]),
    .o_rdata (w_rd_data)
  );

  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= CW'(AF_THRESH));
  assign almost_empty = (r_count <= CW'(AE_THRESH));
  assign count        = r_count;

  generate
    if (FWFT == int'(MODE_FWFT)) begin : g_fwft
      // Head word is always presented; a pop simply advances rd_ptr.
      assign data_out   = w_rd_data;
      assign data_valid = ~w_empty;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] r_dout;
      logic                  r_dv;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_dout <= '0;
          r_dv   <= 1'b0;
        end else begin
          r_dv <= w_rd_acc;
          if (w_rd_acc) r_dout <= w_rd_data;
        end
      end

      assign data_out   = r_dout;
      assign data_valid = r_dv;
    end
  endgenerate

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en && w_full)  r_overflow  <= 1'b1;
      if (rd_en && w_empty) r_underflow <= 1'b1;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

endmodule
